// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Shared state encoding and constants for the fetch/data memory arbiter.
// Rev    : 1.0
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Shares one variable-latency memory between fetch and data stages; optional
// watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MAX_D_STREAK   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ireq,
    input  logic [AW-1:0] iaddr,
    output logic          idone,
    output logic [DW-1:0] irdata,
    input  logic          dreq,
    input  logic          dwe,
    input  logic [AW-1:0] daddr,
    input  logic [DW-1:0] dwdata,
    output logic          ddone,
    output logic [DW-1:0] drdata,
    output logic          stallF,
    output logic          stallM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

    arb_state_t    state_q;
    logic          idone_q, ddone_q, mem_req_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q, irdata_q, drdata_q;
    logic [SW-1:0] streak_q, streak_d;

    logic          w_idle, w_i_elig, w_d_elig, w_streak_max;
    logic          w_grant_i, w_grant_d;
    logic          w_timeout, w_complete;
    logic [DW-1:0] w_rdata;

    // A requester is masked in its own done cycle so a held req is not re-issued.
    assign w_idle       = (state_q == ARB_IDLE);
    assign w_i_elig     = ireq & ~idone_q;
    assign w_d_elig     = dreq & ~ddone_q;
    assign w_streak_max = (streak_q == SW'(MAX_D_STREAK));
    assign w_grant_d    = w_idle & w_d_elig & ~(w_streak_max & w_i_elig);
    assign w_grant_i    = w_idle & w_i_elig & ~w_grant_d;

    always_comb begin
        streak_d = streak_q;
        if (w_grant_d) begin
            if (!w_i_elig) begin
                streak_d = '0;
            end else if (!w_streak_max) begin
                streak_d = streak_q + SW'(1);
            end
        end else if (w_grant_i) begin
            streak_d = '0;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;

    assign w_timeout = ~w_idle & ~mem_ready & (wd_q == TW'(TIMEOUT_CYCLES - 1));
    assign w_rdata   = w_timeout ? DW'(TIMEOUT_DATA) : mem_rdata;
    assign err       = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (w_idle || w_timeout) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + TW'(1);
            end
            if (w_timeout) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_rdata   = mem_rdata;
    assign err       = 1'b0;
`endif

    assign w_complete = mem_ready | w_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            streak_q    <= '0;
        end else begin
            idone_q <= 1'b0;
            ddone_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    streak_q <= streak_d;
                    if (w_grant_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dwe;
                        mem_addr_q  <= daddr;
                        mem_wdata_q <= dwdata;
                        state_q     <= ARB_BUSY_D;
                    end else if (w_grant_i) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= iaddr;
                        state_q     <= ARB_BUSY_I;
                    end
                end
                ARB_BUSY_I: begin
                    if (w_complete) begin
                        mem_req_q <= 1'b0;
                        irdata_q  <= w_rdata;
                        idone_q   <= 1'b1;
                        state_q   <= ARB_IDLE;
                    end
                end
                ARB_BUSY_D: begin
                    if (w_complete) begin
                        mem_req_q <= 1'b0;
                        // Stores keep the last load value unless the watchdog fired.
                        if (!mem_we_q || w_timeout) begin
                            drdata_q <= w_rdata;
                        end
                        ddone_q   <= 1'b1;
                        state_q   <= ARB_IDLE;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign idone     = idone_q;
    assign ddone     = ddone_q;
    assign irdata    = irdata_q;
    assign drdata    = drdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stallF    = ireq & ~idone_q;
    assign stallM    = dreq & ~ddone_q;

endmodule
`default_nettype wire
